// File: rtl/sram_access_sequencer_pkg.sv
// rtl/sram_access_sequencer_pkg.sv - shared types and widths for the SRAM access sequencer
package sram_access_sequencer_pkg;

  localparam int unsigned ADDR_W       = 18;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned WAIT_DEFAULT = 2;
  localparam int unsigned CNT_W        = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ACC,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } state_t;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_t;

  function automatic logic is_write_state(input state_t s);
    return (s == ST_WR_SETUP) || (s == ST_WR_PULSE) || (s == ST_WR_HOLD);
  endfunction

endpackage

// File: rtl/sram_access_sequencer.sv
// rtl/sram_access_sequencer.sv - arbitrates read/write requesters onto an async SRAM
// Strobes, address and bus enable are flopped from the next state so they line up with the FSM.
module sram_access_sequencer
  import sram_access_sequencer_pkg::*;
#(
  parameter int unsigned WAIT = WAIT_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ack_o,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_ack_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic [ADDR_W-1:0] addr_o,
  inout  wire  [DATA_W-1:0] io_io,
  output logic              cs_o,
  output logic              we_o,
  output logic              oe_o,
  output logic              busy_o
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  grant_t              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                cs_q, cs_d;
  logic                we_q, we_d;
  logic                oe_q, oe_d;
  logic                io_en_q, io_en_d;
  logic                rd_grant, wr_grant, rd_done;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    rd_grant     = 1'b0;
    wr_grant     = 1'b0;
    rd_done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Contested requests go to whichever type lost the previous grant.
        if (rd_req_i && (!wr_req_i || last_grant_q == GRANT_WR)) begin
          rd_grant     = 1'b1;
          state_d      = ST_RD_ACC;
          cnt_d        = CNT_LOAD;
          last_grant_d = GRANT_RD;
        end else if (wr_req_i) begin
          wr_grant     = 1'b1;
          state_d      = ST_WR_SETUP;
          cnt_d        = CNT_LOAD;
          last_grant_d = GRANT_WR;
        end
      end
      ST_RD_ACC: begin
        if (cnt_q == '0) begin
          rd_done = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WR_SETUP: state_d = ST_WR_PULSE;
      ST_WR_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_WR_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WR_HOLD: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_done;
    if (rd_grant) begin
      addr_d = rd_addr_i;
    end else if (wr_grant) begin
      addr_d  = wr_addr_i;
      wdata_d = wr_data_i;
    end
    // Sampled on the last RD_ACC edge while oe is still low.
    if (rd_done) begin
      rd_data_d = io_io;
    end
    cs_d    = (state_d == ST_IDLE);
    we_d    = (state_d != ST_WR_PULSE);
    oe_d    = (state_d != ST_RD_ACC);
    io_en_d = is_write_state(state_d);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= GRANT_WR;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      cs_q         <= 1'b1;
      we_q         <= 1'b1;
      oe_q         <= 1'b1;
      io_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      cs_q         <= cs_d;
      we_q         <= we_d;
      oe_q         <= oe_d;
      io_en_q      <= io_en_d;
    end
  end

  assign io_io      = io_en_q ? wdata_q : {DATA_W{1'bz}};
  assign wr_ack_o   = wr_grant;
  assign rd_ack_o   = rd_grant;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign addr_o     = addr_q;
  assign cs_o       = cs_q;
  assign we_o       = we_q;
  assign oe_o       = oe_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_access_sequencer.sv
// tb/tb_sram_access_sequencer.sv - scoreboard bench for sram_access_sequencer (WAIT=2 and WAIT=15)
module tb_sram_access_sequencer;
  import sram_access_sequencer_pkg::*;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;

  logic        wr_req1 = 1'b0, rd_req1 = 1'b0;
  logic [17:0] wr_addr1 = '0, rd_addr1 = '0;
  logic [7:0]  wr_data1 = '0;
  logic        wr_ack1, rd_ack1, rd_valid1, cs1, we1, oe1, busy1;
  logic [7:0]  rd_data1;
  logic [17:0] addr1;
  wire  [7:0]  io1;

  logic        wr_req2 = 1'b0, rd_req2 = 1'b0;
  logic [17:0] wr_addr2 = '0, rd_addr2 = '0;
  logic [7:0]  wr_data2 = '0;
  logic        wr_ack2, rd_ack2, rd_valid2, cs2, we2, oe2, busy2;
  logic [7:0]  rd_data2;
  logic [17:0] addr2;
  wire  [7:0]  io2;

  int checks = 0;
  int passed = 0;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int   wr_ack_cnt1 = 0;
  int   turn_bad = 0, ovl_bad = 0, ack_bad = 0, sp_bad = 0, nv2 = 0;
  int   last_v2 = -1;
  logic prev_oe1 = 1'b1, prev_cs1 = 1'b1;

  logic [7:0] mem [0:262143];

  sram_access_sequencer #(.WAIT(2)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .wr_req_i(wr_req1), .wr_addr_i(wr_addr1), .wr_data_i(wr_data1), .wr_ack_o(wr_ack1),
    .rd_req_i(rd_req1), .rd_addr_i(rd_addr1), .rd_ack_o(rd_ack1),
    .rd_data_o(rd_data1), .rd_valid_o(rd_valid1), .addr_o(addr1), .io_io(io1),
    .cs_o(cs1), .we_o(we1), .oe_o(oe1), .busy_o(busy1)
  );

  sram_access_sequencer #(.WAIT(15)) dut2 (
    .clk_i(clk), .rst_i(rst),
    .wr_req_i(wr_req2), .wr_addr_i(wr_addr2), .wr_data_i(wr_data2), .wr_ack_o(wr_ack2),
    .rd_req_i(rd_req2), .rd_addr_i(rd_addr2), .rd_ack_o(rd_ack2),
    .rd_data_o(rd_data2), .rd_valid_o(rd_valid2), .addr_o(addr2), .io_io(io2),
    .cs_o(cs2), .we_o(we2), .oe_o(oe2), .busy_o(busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM models: dut1 backed by an array, dut2 returns a fixed function of the address.
  assign io1 = (!cs1 && !oe1 && we1) ? mem[addr1] : 8'hzz;
  always @(posedge we1) if (!cs1 && !rst) mem[addr1] <= io1;
  assign io2 = (!cs2 && !oe2) ? (addr2[7:0] ^ 8'h5A) : 8'hzz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_ack(input bit is_rd, output int c);
    c = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (is_rd ? rd_ack1 : wr_ack1) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) check(is_rd ? "rd_ack timeout" : "wr_ack timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (rd_valid1) begin
      if (q1.size() == 0) check("rd_valid1 unexpected", 1, 0);
      else begin
        e1 = q1.pop_front();
        check("rd_data1", rd_data1, e1.data);
        check("rd_valid1 cycle", cyc, e1.cyc);
      end
    end
    if (rd_valid2) begin
      if (q2.size() == 0) check("rd_valid2 unexpected", 1, 0);
      else begin
        e2 = q2.pop_front();
        check("rd_data2", rd_data2, e2.data);
        check("rd_valid2 cycle", cyc, e2.cyc);
      end
      if (last_v2 >= 0 && cyc - last_v2 != 16) sp_bad <= sp_bad + 1;
      last_v2 <= cyc;
      nv2 <= nv2 + 1;
    end
    if (wr_ack1) wr_ack_cnt1 <= wr_ack_cnt1 + 1;
    if (wr_ack1 && rd_ack1) ack_bad <= ack_bad + 1;
    if (rd_valid1 && wr_ack1 && !rd_ack1 && 1'b0) ack_bad <= ack_bad + 1;
    if (!oe1 && prev_oe1 && !prev_cs1) turn_bad <= turn_bad + 1;
    if (!oe1 && dut1.io_en_q) ovl_bad <= ovl_bad + 1;
    prev_oe1 <= oe1;
    prev_cs1 <= cs1;
  end

  initial begin
    int c, cw, cr, ng;
    string exp_seq;
    byte   seq[$];
    mem[18'h00010] = 8'hA5;
    mem[18'h00123] = 8'h77;

    // reset state
    repeat (2) @(negedge clk);
    check("rst cs", cs1, 1);
    check("rst we", we1, 1);
    check("rst oe", oe1, 1);
    check("rst addr", addr1, 0);
    check("rst rd_data", rd_data1, 0);
    check("rst busy/acks/valid", {busy1, wr_ack1, rd_ack1, rd_valid1}, 0);
    check("rst io_en", dut1.io_en_q, 0);
    @(posedge clk); #1 rst = 1'b0;

    // single read, WAIT=2
    @(posedge clk); #1 rd_addr1 = 18'h00010; rd_req1 = 1'b1;
    wait_ack(1, c);
    if (c >= 0) q1.push_back('{8'hA5, c + 3});
    @(posedge clk); #1 rd_req1 = 1'b0;
    @(negedge clk); check("read oe cyc1", oe1, 0);
    @(negedge clk); check("read oe cyc2", oe1, 0);
    check("read addr", addr1, 18'h00010);
    @(negedge clk); check("read oe after", oe1, 1);
    check("read rd_valid at N+3", rd_valid1, 1);

    // single write of 0x3C to 0x3FFFF
    @(posedge clk); #1 wr_addr1 = 18'h3FFFF; wr_data1 = 8'h3C; wr_req1 = 1'b1;
    wait_ack(0, c);
    @(posedge clk); #1 wr_req1 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("write we k=%0d", k), we1, (k == 2 || k == 3) ? 1'b0 : 1'b1);
      check($sformatf("write cs k=%0d", k), cs1, (k == 5) ? 1'b1 : 1'b0);
      check($sformatf("write oe k=%0d", k), oe1, 1);
      if (k <= 4) check($sformatf("write io k=%0d", k), io1, 8'h3C);
      else check("write io released", dut1.io_en_q, 0);
    end
    check("write addr", addr1, 18'h3FFFF);
    check("mem[3FFFF]", mem[18'h3FFFF], 8'h3C);

    // write then immediate read of the same address
    @(posedge clk); #1 wr_addr1 = 18'h01234; wr_data1 = 8'h5E; wr_req1 = 1'b1;
    wait_ack(0, cw);
    @(posedge clk); #1 wr_req1 = 1'b0; rd_addr1 = 18'h01234; rd_req1 = 1'b1;
    wait_ack(1, cr);
    if (cr >= 0) q1.push_back('{8'h5E, cr + 3});
    check("w->r grant cycle", cr - cw, 5);
    check("turnaround cs/oe", {cs1, oe1}, 2'b11);
    check("turnaround io_en", dut1.io_en_q, 0);
    @(posedge clk); #1 rd_req1 = 1'b0;
    repeat (4) @(negedge clk);

    // reset during first WR_PULSE cycle
    @(posedge clk); #1 wr_addr1 = 18'h00200; wr_data1 = 8'hEE; wr_req1 = 1'b1;
    wait_ack(0, c);
    @(posedge clk); #1 wr_req1 = 1'b0;
    @(negedge clk);
    @(negedge clk); check("abort we low before rst", we1, 0);
    rst = 1'b1;
    #1;
    check("abort we", we1, 1);
    check("abort io_en", dut1.io_en_q, 0);
    check("abort busy/cs", {busy1, cs1}, 2'b01);
    ng = wr_ack_cnt1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort no ack", wr_ack_cnt1, ng);
    check("abort idle", busy1, 0);

    // contested requests held for 4 grants
    @(posedge clk); #1
    rd_addr1 = 18'h00123; wr_addr1 = 18'h00300; wr_data1 = 8'h99;
    rd_req1 = 1'b1; wr_req1 = 1'b1;
    for (int n = 0; n < 300 && seq.size() < 4; n++) begin
      @(negedge clk);
      if (rd_ack1) begin
        seq.push_back("R");
        q1.push_back('{8'h77, cyc + 3});
      end
      if (wr_ack1) seq.push_back("W");
    end
    @(posedge clk); #1 rd_req1 = 1'b0; wr_req1 = 1'b0;
    exp_seq = "RWRW";
    check("contested grant count", seq.size(), 4);
    for (int k = 0; k < 4 && k < seq.size(); k++)
      check($sformatf("grant %0d", k), seq[k], exp_seq[k]);
    for (int n = 0; n < 50 && busy1; n++) @(negedge clk);
    check("mem[300]", mem[18'h00300], 8'h99);

    // WAIT=15, 16 back-to-back reads
    @(posedge clk); #1 rd_addr2 = 18'd0; rd_req2 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      c = -1;
      for (int n = 0; n < 60; n++) begin
        @(negedge clk);
        if (rd_ack2) begin
          c = cyc;
          break;
        end
      end
      if (c < 0) check("rd_ack2 timeout", 0, 1);
      else q2.push_back('{8'(i) ^ 8'h5A, c + 16});
      @(posedge clk); #1 rd_addr2 = 18'(i + 1);
      if (i == 15) rd_req2 = 1'b0;
    end

    for (int n = 0; n < 100 && (q1.size() != 0 || q2.size() != 0); n++) @(negedge clk);
    @(negedge clk);
    check("q1 drained", q1.size(), 0);
    check("q2 drained", q2.size(), 0);
    check("rd_valid2 count", nv2, 16);
    check("rd_valid2 spacing", sp_bad, 0);
    check("turnaround violations", turn_bad, 0);
    check("oe/io overlap", ovl_bad, 0);
    check("ack overlap", ack_bad, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
